// File: rtl/puf_challenge_sequencer.sv
// puf_challenge_sequencer
//   Initiator for the RO-PUF core. For each of RESP_BITS challenges it holds
//   the PUF in reset with the ring oscillators off for SETTLE_CYCLES, lets the
//   oscillators and post-mux counters run for MEASURE_CYCLES, then spends one
//   cycle sampling the race arbiter bit into the response shift register and
//   advancing the challenge. A one-cycle done pulse marks a valid response.
//
// Optional feature macro: PUF_SEQ_LFSR_EN
//   defined   : challenge advances as an 8-bit Fibonacci LFSR
//               (x^8+x^6+x^5+x^4+1); a zero seed is loaded as 8'h01.
//   undefined : challenge advances by +1 with 8-bit wrap; seed loaded as-is.
//
// Ports
//   clock      in   1          clock
//   reset      in   1          synchronous, active-low
//   start      in   1          level request, only honoured in IDLE
//   seed       in   8          first challenge of a run
//   puf_resp   in   1          race arbiter result from the PUF core
//   challenge  out  8          mux selects ([3:0] mux A, [7:4] mux B)
//   enable     out  32         ring oscillator enables, all-0 or all-1
//   puf_reset  out  1          active-low reset to the post-mux counters
//   busy       out  1          run in progress
//   done       out  1          one-cycle pulse, response valid
//   response   out  RESP_BITS  collected bits, first challenge in the MSB
module puf_challenge_sequencer #(
  parameter int RESP_BITS      = 16,
  parameter int SETTLE_CYCLES  = 64,
  parameter int MEASURE_CYCLES = 256
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic [7:0]           seed,
  input  logic                 puf_resp,
  output logic [7:0]           challenge,
  output logic [31:0]          enable,
  output logic                 puf_reset,
  output logic                 busy,
  output logic                 done,
  output logic [RESP_BITS-1:0] response
);

  localparam int MAX_PHASE = (SETTLE_CYCLES > MEASURE_CYCLES) ? SETTLE_CYCLES : MEASURE_CYCLES;
  localparam int PH_W      = $clog2(MAX_PHASE) + 1;
  localparam int BIT_W     = $clog2(RESP_BITS + 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_RUN    = 3'd2,
    ST_SAMPLE = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t               state_q, state_d;
  logic [PH_W-1:0]      phase_q, phase_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [7:0]           challenge_q, challenge_d;
  logic [RESP_BITS-1:0] response_q, response_d;

  logic             settle_last;
  logic             measure_last;
  logic [BIT_W-1:0] bit_inc;
  logic             last_bit;

  // Challenge loaded from the seed at run start.
  function automatic logic [7:0] first_challenge(input logic [7:0] s);
`ifdef PUF_SEQ_LFSR_EN
    // The all-zero state would lock the LFSR, so it is replaced by 8'h01.
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  // Challenge following c.
  function automatic logic [7:0] next_challenge(input logic [7:0] c);
`ifdef PUF_SEQ_LFSR_EN
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
`else
    return c + 8'd1;
`endif
  endfunction

  assign settle_last  = (phase_q == PH_W'(SETTLE_CYCLES - 1));
  assign measure_last = (phase_q == PH_W'(MEASURE_CYCLES - 1));
  assign bit_inc      = bit_q + BIT_W'(1);
  assign last_bit     = (bit_inc == BIT_W'(RESP_BITS));

  // State register (and datapath registers)
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      phase_q     <= '0;
      bit_q       <= '0;
      challenge_q <= 8'h00;
      response_q  <= '0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      bit_q       <= bit_d;
      challenge_q <= challenge_d;
      response_q  <= response_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_SETTLE;
      ST_SETTLE: if (settle_last) state_d = ST_RUN;
      ST_RUN:    if (measure_last) state_d = ST_SAMPLE;
      ST_SAMPLE: state_d = last_bit ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath next values
  always_comb begin
    phase_d     = phase_q;
    bit_d       = bit_q;
    challenge_d = challenge_q;
    response_d  = response_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          challenge_d = first_challenge(seed);
          response_d  = '0;
          bit_d       = '0;
          phase_d     = '0;
        end
      end
      ST_SETTLE: phase_d = settle_last ? '0 : phase_q + PH_W'(1);
      ST_RUN:    phase_d = measure_last ? '0 : phase_q + PH_W'(1);
      ST_SAMPLE: begin
        // The arbiter bit reflects the challenge still on the mux selects.
        response_d  = {response_q[RESP_BITS-2:0], puf_resp};
        challenge_d = next_challenge(challenge_q);
        bit_d       = bit_inc;
        phase_d     = '0;
      end
      ST_DONE:   ;
      default:   ;
    endcase
  end

  // Outputs
  always_comb begin
    enable    = 32'h0000_0000;
    puf_reset = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state_q)
      ST_IDLE:   ;
      ST_SETTLE: busy = 1'b1;
      ST_RUN, ST_SAMPLE: begin
        // Oscillators stay enabled through the sample cycle so the arbiter
        // result is stable while it is captured.
        enable    = 32'hFFFF_FFFF;
        puf_reset = 1'b1;
        busy      = 1'b1;
      end
      ST_DONE:   done = 1'b1;
      default:   ;
    endcase
  end

  assign challenge = challenge_q;
  assign response  = response_q;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
module tb_puf_challenge_sequencer;

  localparam int B = 4;
  localparam int S = 4;
  localparam int M = 8;
  localparam int RUN_LEN = B * (S + M + 1);

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [7:0]   seed  = 8'h00;
  logic         puf_resp;
  logic [7:0]   challenge;
  logic [31:0]  enable;
  logic         puf_reset;
  logic         busy;
  logic         done;
  logic [B-1:0] response;

  // Behavioural PUF: arbiter bit = parity(challenge & key) ^ inv.
  logic [7:0] key = 8'h00;
  logic       inv = 1'b0;
  assign puf_resp = (^(challenge & key)) ^ inv;

  puf_challenge_sequencer #(
    .RESP_BITS(B), .SETTLE_CYCLES(S), .MEASURE_CYCLES(M)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .seed(seed), .puf_resp(puf_resp),
    .challenge(challenge), .enable(enable), .puf_reset(puf_reset), .busy(busy),
    .done(done), .response(response)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int done_cnt = 0;
  int rise_cnt = 0;

  typedef struct {
    logic [B-1:0] resp;
    int           acc;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] chal_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end else begin
      $display("ok   %s: %0h (cycle %0d)", name, act, cyc);
    end
  endtask

  function automatic logic [7:0] model_first(input logic [7:0] s);
`ifdef PUF_SEQ_LFSR_EN
    return (s == 8'h00) ? 8'h01 : s;
`else
    return s;
`endif
  endfunction

  function automatic logic [7:0] model_next(input logic [7:0] c);
`ifdef PUF_SEQ_LFSR_EN
    return {c[6:0], c[7] ^ c[5] ^ c[4] ^ c[3]};
`else
    return 8'((int'(c) + 1) % 256);
`endif
  endfunction

  // Reference model: expected challenge sequence and response for one run.
  task automatic expect_run(input logic [7:0] s, input int acc);
    logic [7:0] c;
    int r;
    exp_t e;
    c = model_first(s);
    r = 0;
    for (int i = 0; i < B; i++) begin
      chal_q.push_back(c);
      r = r * 2 + int'((^(c & key)) ^ inv);
      c = model_next(c);
    end
    e.resp = B'(r);
    e.acc  = acc;
    exp_q.push_back(e);
  endtask

  // Monitor: sampled on the falling edge.
  logic en_prev = 1'b0;
  int   hi_len = 0;
  int   settle_cnt = 0;
  logic aborted = 1'b0;

  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      aborted    = 1'b1;
      settle_cnt = 0;
    end
    check("en_matches_puf_reset", {enable, puf_reset}, {{32{puf_reset}}, puf_reset});
    if (enable[0] && !en_prev) begin
      rise_cnt++;
      if (!aborted || settle_cnt != 0) check("settle_len", 64'(settle_cnt), 64'(S));
      aborted    = 1'b0;
      settle_cnt = 0;
      hi_len     = 1;
      if (chal_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_run: challenge %0h with no expectation", challenge);
      end else begin
        check("challenge", 64'(challenge), 64'(chal_q.pop_front()));
      end
    end else if (enable[0]) begin
      hi_len++;
    end else if (en_prev && !aborted) begin
      check("run_len", 64'(hi_len), 64'(M + 1));
    end
    if (enable[0]) check("busy_in_run", 64'(busy), 64'd1);
    if (busy && !enable[0] && reset) settle_cnt++;
    if (done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: response %0h with no expectation", response);
      end else begin
        e = exp_q.pop_front();
        check("response", 64'(response), 64'(e.resp));
        // done occupies the clock period beginning RUN_LEN edges after the accept edge
        check("latency", 64'(cyc - e.acc), 64'(RUN_LEN));
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
    en_prev = enable[0];
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_outs"}, {challenge, enable, puf_reset, busy, done, 4'(response)}, 64'd0);
  endtask

  task automatic wait_done();
    int d0;
    d0 = done_cnt;
    for (int i = 0; i < RUN_LEN + 20 && done_cnt == d0; i++) tick();
    if (done_cnt == d0) begin
      n_vec++; n_err++;
      $display("FAIL done_timeout: no done within %0d cycles", RUN_LEN + 20);
    end
  endtask

  task automatic launch(input logic [7:0] s, input logic [7:0] k, input logic iv);
    key   = k;
    inv   = iv;
    seed  = s;
    start = 1'b1;
    tick();
    expect_run(s, cyc);
    start = 1'b0;
    check("busy_after_accept", 64'(busy), 64'd1);
  endtask

  task automatic run_one(input logic [7:0] s, input logic [7:0] k, input logic iv);
    launch(s, k, iv);
    wait_done();
    tick();
    tick();
  endtask

  initial begin
    int d0, r0, acc;
    // Reset held low with start high: nothing may start.
    reset = 1'b0;
    start = 1'b1;
    seed  = 8'h55;
    repeat (2) begin
      tick();
      check_reset_outputs("reset");
    end
    start = 1'b0;
    reset = 1'b1;
    tick();
    check_reset_outputs("idle");

    // All-ones arbiter, then arbiter = challenge[0].
    run_one(8'h10, 8'h00, 1'b1);
    run_one(8'h10, 8'h01, 1'b0);

    // Wrap seed plus an ignored start mid-run.
    d0 = done_cnt;
    launch(8'hFE, 8'($urandom), 1'($urandom));
    repeat (20) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done();
    repeat (RUN_LEN + 10) tick();
    check("single_done", 64'(done_cnt - d0), 64'd1);

    // Reset during the third RUN phase aborts without done.
    r0 = rise_cnt;
    launch(8'h3C, 8'($urandom), 1'($urandom));
    for (int i = 0; i < RUN_LEN && rise_cnt < r0 + 3; i++) tick();
    check("third_run_reached", 64'(rise_cnt - r0), 64'd3);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check_reset_outputs("abort");
    reset = 1'b1;
    exp_q.delete();
    chal_q.delete();
    d0 = done_cnt;
    repeat (RUN_LEN + 10) tick();
    check("no_done_after_abort", 64'(done_cnt - d0), 64'd0);
    run_one(8'hA7, 8'($urandom), 1'($urandom));

    // Seeds that exercise the LFSR zero-seed rule and its feedback.
    run_one(8'h00, 8'($urandom), 1'($urandom));
    run_one(8'h80, 8'($urandom), 1'($urandom));

    // start held high through DONE restarts two cycles after done appears.
    key   = 8'($urandom);
    inv   = 1'($urandom);
    seed  = 8'h61;
    start = 1'b1;
    tick();
    acc = cyc;
    expect_run(8'h61, acc);
    expect_run(8'h61, acc + RUN_LEN + 2);
    wait_done();
    tick();
    tick();
    start = 1'b0;
    wait_done();
    tick();
    tick();

    // Randomised runs.
    for (int i = 0; i < 6; i++) run_one(8'($urandom), 8'($urandom), 1'($urandom));

    repeat (5) tick();
    check("exp_q_drained", 64'(exp_q.size()), 64'd0);
    check("chal_q_drained", 64'(chal_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
